// File: rtl/jtbubl_snd_pkg.sv
// Shared constants for the sound-side comm link: register offsets and FSM encodings.
`timescale 1ns/1ps
package jtbubl_snd_pkg;

  localparam logic [1:0] REG_CMD   = 2'd0;
  localparam logic [1:0] REG_STAT  = 2'd1;
  localparam logic [1:0] REG_NMION = 2'd2;

  typedef enum logic {
    PS_IDLE,
    PS_ACTIVE
  } pulse_st_t;

  typedef enum logic [1:0] {
    SR_HOLD,
    SR_COUNT,
    SR_RUN
  } rst_st_t;

endpackage

// File: rtl/jtbubl_cen_pulse.sv
// Clock-enable counted pulse: starts on trig, stays busy for LEN cen ticks after that.
`timescale 1ns/1ps
module jtbubl_cen_pulse
  import jtbubl_snd_pkg::*;
#(
  parameter int unsigned CW  = 8,
  parameter int unsigned LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  input  logic trig,
  input  logic clr,
  output logic busy
);

  pulse_st_t     st;
  logic [CW-1:0] cnt;

  // Start does not wait for cen; callers gate trig with cen where the start must align to a tick.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      st   <= PS_IDLE;
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      case (st)
        PS_IDLE: begin
          if (trig) begin
            st   <= PS_ACTIVE;
            cnt  <= CW'(LEN);
            busy <= 1'b1;
          end
        end
        PS_ACTIVE: begin
          if (cen) begin
            if (cnt == CW'(1)) begin
              st   <= PS_IDLE;
              busy <= 1'b0;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        default: st <= PS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/jtbubl_sndcomm.sv
// Sound-side end of the main/sound CPU link: command latch, reply latch, NMI and sound CPU reset.
`timescale 1ns/1ps
module jtbubl_sndcomm
  import jtbubl_snd_pkg::*;
#(
  parameter int unsigned NMI_W    = 4,
  parameter int unsigned RST_HOLD = 16
) (
  input  logic       clk24,
  input  logic       rst,
  input  logic       cen3,
  input  logic [7:0] snd_latch,
  input  logic       snd_stb,
  input  logic       snd_rstn,
  output logic [7:0] main_latch,
  output logic       main_stb,
  output logic       snd_flag,
  input  logic       comm_cs,
  input  logic [1:0] comm_addr,
  input  logic       comm_rnw,
  input  logic [7:0] comm_din,
  output logic [7:0] comm_dout,
  output logic       snd_nmi_n,
  output logic       snd_cpu_rst_n
);

  logic       stb_l, cs_l;
  logic       stb_edge, cs_edge, rd, wr, wr_stat, wr_nmion;
  logic [7:0] cmd, rd_data;
  logic       pend, nmi_en, nmi_req;
  logic       in_reset, nmi_trig, nmi_busy, hold_busy;
  rst_st_t    rst_st;

  // Combinational hold so clears take effect on the clk24 after snd_rstn falls.
  assign in_reset = rst | ~snd_rstn | (rst_st != SR_RUN);
  assign stb_edge = snd_stb & ~stb_l & ~in_reset;
  assign cs_edge  = comm_cs & ~cs_l & ~in_reset;
  assign rd       = cs_edge & comm_rnw;
  assign wr       = cs_edge & ~comm_rnw;
  assign wr_stat  = wr & (comm_addr == REG_STAT);
  assign wr_nmion = wr & (comm_addr == REG_NMION);
  assign nmi_trig = nmi_req & cen3 & ~in_reset;
  assign snd_flag  = pend;
  assign snd_nmi_n = ~nmi_busy;

  always_comb begin
    rd_data = 8'hff;
    case (comm_addr)
      REG_CMD:  rd_data = cmd;
      REG_STAT: rd_data = {6'h3f, nmi_en, pend};
      default:  rd_data = 8'hff;
    endcase
  end

  always_ff @(posedge clk24) begin
    stb_l <= snd_stb;
    cs_l  <= comm_cs;
    if (rst) begin
      cmd        <= '0;
      pend       <= 1'b0;
      nmi_en     <= 1'b0;
      nmi_req    <= 1'b0;
      main_latch <= '0;
      main_stb   <= 1'b0;
      comm_dout  <= '1;
    end else begin
      main_stb <= 1'b0;
      if (in_reset) begin
        pend    <= 1'b0;
        nmi_en  <= 1'b0;
        nmi_req <= 1'b0;
      end else begin
        if (nmi_trig && !nmi_busy) nmi_req <= 1'b0;
        if (rd) begin
          comm_dout <= rd_data;
          if (comm_addr == REG_CMD) pend <= 1'b0;
        end
        if (wr) begin
          case (comm_addr)
            REG_CMD: begin
              main_latch <= comm_din;
              main_stb   <= 1'b1;
            end
            REG_STAT:  nmi_en <= 1'b0;
            REG_NMION: begin
              nmi_en <= 1'b1;
              if (pend) nmi_req <= 1'b1;
            end
            default: ;
          endcase
        end
        // Strobe handled last so a coincident read still sees pend set afterwards.
        if (stb_edge) begin
          cmd  <= snd_latch;
          pend <= 1'b1;
          if ((nmi_en || wr_nmion) && !wr_stat) nmi_req <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk24) begin
    if (rst || !snd_rstn) begin
      rst_st        <= SR_HOLD;
      snd_cpu_rst_n <= 1'b0;
    end else begin
      case (rst_st)
        SR_HOLD:  rst_st <= SR_COUNT;
        SR_COUNT: begin
          if (!hold_busy) begin
            rst_st        <= SR_RUN;
            snd_cpu_rst_n <= 1'b1;
          end
        end
        SR_RUN:   ;
        default:  rst_st <= SR_HOLD;
      endcase
    end
  end

  jtbubl_cen_pulse #(.CW(4), .LEN(NMI_W)) u_nmi (
    .clk  (clk24),
    .rst  (rst),
    .cen  (cen3),
    .trig (nmi_trig),
    .clr  (in_reset),
    .busy (nmi_busy)
  );

  jtbubl_cen_pulse #(.CW(8), .LEN(RST_HOLD)) u_hold (
    .clk  (clk24),
    .rst  (rst),
    .cen  (cen3),
    .trig ((rst_st == SR_HOLD) & snd_rstn & ~rst),
    .clr  (rst | ~snd_rstn),
    .busy (hold_busy)
  );

endmodule
